fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction fetch front end that sits directly upstream of the instruction memory and feeds the decode stage. It owns the program counter and drives the memory word address. It captures the combinational read data into a small in-order fetch buffer. Buffered {pc, instr} pairs go to decode over a valid/ready handshake, and a redirect input from execute handles taken branches and jumps.

Parameters:
XLEN, 32, datapath/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned)
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
imem_addr  output  XLEN  byte address to instruction memory (equals current PC)
imem_rdata  input  32  instruction word, combinational from imem_addr, same cycle
redirect_valid  input  1  execute requests PC change this cycle
redirect_target  input  XLEN  new PC; bits [1:0] ignored (forced to 00)
id_valid  output  1  buffer head holds a valid instruction
id_ready  input  1  decode accepts head this cycle
id_instr  output  32  instruction at buffer head
id_pc  output  XLEN  PC of that instruction
id_pc_plus4  output  XLEN  id_pc + 4 (mod 2^XLEN)

Behaviour:
- Reset (rst=0, asynchronous): pc <= RESET_PC; count, read and write pointers <= 0; id_valid=0. id_instr, id_pc and id_pc_plus4 drive 0 while empty.
- imem_addr = pc at all times (combinational from the pc register).
- pop = id_valid & id_ready.
- push = ~redirect_valid & (count < FIFO_DEPTH | pop). Push-on-full is allowed when a pop occurs in the same cycle.
- On push: write {pc, imem_rdata} at the write pointer; pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- If no push and no redirect: pc holds.
- Redirect has priority over push and pop:
  - flush all entries (count <= 0, pointers <= 0); id_valid=0 next cycle;
  - pc <= {redirect_target[XLEN-1:2], 2'b00};
  - imem_rdata in the redirect cycle is discarded;
  - a pop handshake in the redirect cycle still counts as a completed transfer for decode.
- Latency: fetched at PC in cycle N -> visible at id_* in cycle N+1 (registered buffer, no combinational imem->id path).
- After redirect in cycle N: target word is fetched in N+1 and presented in N+2 (one bubble).
- Sustained throughput: 1 instr/cycle while id_ready=1 and no redirect.
- Backpressure: id_ready=0 with buffer full -> pc and imem_addr hold, and id_* hold stable until accepted.
- id_* outputs must not change while id_valid=1 and id_ready=0.
- count is always in 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation: immediate flush, pc=RESET_PC; no partial state survives.
- No FSM beyond the buffer occupancy, which is implicit in count: EMPTY (0), PARTIAL, FULL (FIFO_DEPTH).
- imem_rdata value is never inspected; all-ones and zero words are buffered like any other.

Decomposition:
- Package fetch_pkg:
  - XLEN and RESET_PC defaults;
  - INSTR_W=32, PC_INC=4;
  - typedef fetch_entry_t {pc[XLEN], instr[32]}.
- Sub-module fetch_fifo: generic FIFO_DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty flags, on the same async active-low rst.
- fetch_stage contains the pc register, the increment/redirect mux, and the push/pop control.

Test Plan:
- Reset release with RESET_PC=0, memory words 0x20080005, 0x20090003, 0x01095020, id_ready=1:
  - imem_addr steps 0,4,8 on consecutive cycles;
  - id_pc/id_instr = 0/0x20080005 in cycle 1, then 4/0x20090003, then 8/0x01095020;
  - id_pc_plus4 = id_pc+4.
- Backpressure with id_ready=0 from cycle 1:
  - count reaches 2 with PCs 0 and 4 buffered, and imem_addr stalls at 8;
  - id_pc stays 0 throughout;
  - raise id_ready: deliveries 0, 4, 8 in order, with no duplicate or dropped entry.
- Redirect to 0x40 in cycle 3 while the buffer holds 2 entries:
  - id_valid=0 in cycle 4;
  - imem_addr=0x40 in cycle 4;
  - id_pc=0x40 in cycle 5.
- Misaligned redirect_target 0x43 -> next imem_addr 0x40.
- Redirect in the same cycle as pop with buffer full -> buffer empties, and the pc load wins over the increment.
- Wrap: redirect to 0xFFFF_FFFC:
  - next fetch address is 0x0000_0000;
  - id_pc_plus4 for that entry is 0.
- Async reset pulse mid-stream (not clock-aligned):
  - id_valid drops immediately and imem_addr=RESET_PC;
  - normal fetch resumes from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// The buffer entry pairs a fetch PC with the instruction word read at that PC.
package fetch_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam int              INSTR_W  = 32;
    localparam int              PC_INC   = 4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer: DEPTH entries of fetch_entry_t with push, pop and flush.
// Push on full is accepted when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wr_data,
    output fetch_entry_t o_rd_data,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Flush overrides both sides so nothing captured in a redirect cycle survives.
    assign w_pop  = i_pop  & ~o_empty & ~i_flush;
    assign w_push = i_push & ~i_flush & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, drives imem, buffers {pc, instr}
// for decode over valid/ready, and handles redirects from execute.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_pc_plus4
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_wr_entry;
    fetch_entry_t    w_head;

    assign imem_addr     = r_pc;
    assign w_redirect_pc = redirect_target & ~XLEN'(3);

    assign w_pop  = id_valid & id_ready;
    assign w_push = ~redirect_valid & (~w_full | w_pop);

    assign w_wr_entry.pc    = r_pc;
    assign w_wr_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(PC_INC);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (redirect_valid),
        .i_wr_data (w_wr_entry),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Head fields are forced to zero when empty so stale storage never leaks out.
    assign id_valid    = (w_count != '0);
    assign id_instr    = w_empty ? '0 : w_head.instr;
    assign id_pc       = w_empty ? '0 : w_head.pc;
    assign id_pc_plus4 = w_empty ? '0 : w_head.pc + XLEN'(PC_INC);

endmodule
